// File: rtl/red_seq_pkg.sv
// rtl/red_seq_pkg.sv - shared constants and types for the reduction sequencer
package red_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Accumulator / result width
    localparam int RED_W    = 16;

    // Per-beat reduction value: signed 7-bit, bounded to [-64, 63]
    localparam int BEAT_W   = 7;
    localparam int BEAT_MIN = -64;
    localparam int BEAT_MAX = 63;

    // Sign-extend one reduction value to accumulator width
    function automatic logic [RED_W-1:0] sext_beat(input logic [BEAT_W-1:0] v);
        return {{(RED_W-BEAT_W){v[BEAT_W-1]}}, v};
    endfunction

endpackage

// File: rtl/red_seq_red.sv
// rtl/red_seq_red.sv - reduction tree: nibble sum minus 16 per carry bit
module red
    import red_seq_pkg::*;
(
    input  logic [15:0]       i_psum,
    input  logic [3:0]        i_carry,
    output logic [BEAT_W-1:0] o_red
);

    logic [5:0] w_nib_sum;
    logic [2:0] w_carry_cnt;

    // Four unsigned 4-bit partial sums fold to at most 60
    assign w_nib_sum = {2'b00, i_psum[3:0]}   + {2'b00, i_psum[7:4]} +
                       {2'b00, i_psum[11:8]}  + {2'b00, i_psum[15:12]};

    // Each carry-out bit weighs -16, so four carries give -64
    assign w_carry_cnt = {2'b00, i_carry[0]} + {2'b00, i_carry[1]} +
                         {2'b00, i_carry[2]} + {2'b00, i_carry[3]};

    // Difference is in [-64, 60]; 7-bit two's complement is exact
    assign o_red = {1'b0, w_nib_sum} - {w_carry_cnt, 4'b0000};

endmodule

// File: rtl/red_seq.sv
// rtl/red_seq.sv - burst sequencer accumulating reduction-tree results
module red_seq
    import red_seq_pkg::*;
#(
    // Must stay <= 511 so that 64 * MAX_BEATS cannot wrap the accumulator
    parameter int MAX_BEATS = 8,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_len,
    input  logic              i_abort,
    input  logic              i_in_valid,
    input  logic [15:0]       i_psum,
    input  logic [3:0]        i_carry,
    output logic              o_in_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [RED_W-1:0]  o_acc,
    output logic [CNT_W-1:0]  o_beats_left
);

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BEATS);

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [RED_W-1:0]   r_acc;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;

    logic [BEAT_W-1:0]  w_red;
    logic [RED_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_len_clamped;

    red u_red (
        .i_psum  (i_psum),
        .i_carry (i_carry),
        .o_red   (w_red)
    );

    assign w_len_clamped = (i_len > MAX_LEN) ? MAX_LEN : i_len;
    assign w_acc_next    = r_acc + sext_beat(w_red);

    // Control FSM with counter, accumulator and registered handshake outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (i_abort) begin
            // Flush drops the burst but leaves the partial sum visible
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_in_valid) begin
                        r_acc   <= w_acc_next;
                        r_count <= r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1)) begin
                            r_state    <= ST_DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new burst; DONE lasts one cycle
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_acc <= '0;
                        if (w_len_clamped != '0) begin
                            r_state    <= ST_RUN;
                            r_count    <= w_len_clamped;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_count <= '0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_acc        = r_acc;
    assign o_beats_left = r_count;

    // Every accepted beat must lie in the documented reduction range
    a_beat_range: assert property (@(posedge i_clk) disable iff (i_rst)
        (r_state == ST_RUN && i_in_valid) |->
        (int'($signed(w_red)) >= BEAT_MIN && int'($signed(w_red)) <= BEAT_MAX));

    // The unused encoding is never reached
    a_state_legal: assert property (@(posedge i_clk) disable iff (i_rst)
        r_state != state_t'(2'd3));

endmodule

// File: tb/tb_red_seq.sv
// tb/tb_red_seq.sv - scoreboard bench for red_seq with a reference model
module tb_red_seq;

    localparam int MAX_BEATS = 8;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    logic             clk;
    logic             rst;
    logic             i_start;
    logic [CNT_W-1:0] i_len;
    logic             i_abort;
    logic             i_in_valid;
    logic [15:0]      i_psum;
    logic [3:0]       i_carry;
    logic             o_in_ready;
    logic             o_busy;
    logic             o_done;
    logic [15:0]      o_acc;
    logic [CNT_W-1:0] o_beats_left;

    int          errors;
    int          checks;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    red_seq #(.MAX_BEATS(MAX_BEATS)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (i_start),
        .i_len        (i_len),
        .i_abort      (i_abort),
        .i_in_valid   (i_in_valid),
        .i_psum       (i_psum),
        .i_carry      (i_carry),
        .o_in_ready   (o_in_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_acc        (o_acc),
        .o_beats_left (o_beats_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: nibbles add as unsigned values, each carry bit is worth -16
    function automatic int red_ref(input logic [15:0] ps, input logic [3:0] cy);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += int'(ps[4*i +: 4]);
        s -= 16 * $countones(cy);
        return s;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding burst result
    always @(negedge clk) begin
        if (!rst && o_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("done_acc", int'(o_acc), int'(mon_exp));
            end
        end
    end

    task automatic run_burst(input int n_len, input int gap, input bit rnd, input bit b2b,
                             input logic [15:0] ps_fix, input logic [3:0] cy_fix);
        int          nb;
        int          exp_sum;
        int          busy_cyc;
        logic [15:0] ps;
        logic [3:0]  cy;
        nb       = (n_len > MAX_BEATS) ? MAX_BEATS : n_len;
        exp_sum  = 0;
        busy_cyc = 0;
        if (!b2b) begin
            @(posedge clk); #1;
        end
        i_start = 1'b1;
        i_len   = CNT_W'(n_len);
        if (nb == 0) exp_q.push_back(16'h0000);
        @(posedge clk); #1;
        i_start = 1'b0;
        if (nb == 0) begin
            check("zero_len_done", int'(o_done), 1);
            check("zero_len_busy", int'(o_busy), 0);
            check("zero_len_ready", int'(o_in_ready), 0);
            return;
        end
        for (int k = 0; k < nb; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    i_in_valid = 1'b0;
                    if (rnd) begin
                        i_start = 1'($urandom_range(0, 1));
                        i_len   = CNT_W'($urandom);
                    end
                    check("gap_busy", int'(o_busy), 1);
                    check("gap_beats_left", int'(o_beats_left), nb - k);
                    if (o_busy) busy_cyc++;
                    @(posedge clk); #1;
                end
            end
            ps = rnd ? 16'($urandom) : ps_fix;
            cy = rnd ? 4'($urandom)  : cy_fix;
            i_in_valid = 1'b1;
            i_psum     = ps;
            i_carry    = cy;
            if (rnd) begin
                i_start = 1'($urandom_range(0, 1));
                i_len   = CNT_W'($urandom);
            end
            check("beat_ready", int'(o_in_ready), 1);
            check("beats_left", int'(o_beats_left), nb - k);
            if (o_busy) busy_cyc++;
            exp_sum += red_ref(ps, cy);
            if (k == nb - 1) exp_q.push_back(16'(exp_sum));
            @(posedge clk); #1;
        end
        i_in_valid = 1'b0;
        i_start    = 1'b0;
        check("done_pulse", int'(o_done), 1);
        check("busy_cycles", busy_cyc, nb + gap * (nb - 1));
        check("done_busy", int'(o_busy), 0);
        check("done_beats_left", int'(o_beats_left), 0);
    endtask

    task automatic run_abort(input int n_len, input int n_before);
        @(posedge clk); #1;
        i_start = 1'b1;
        i_len   = CNT_W'(n_len);
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < n_before; k++) begin
            i_in_valid = 1'b1;
            i_psum     = 16'h0001;
            i_carry    = 4'h0;
            @(posedge clk); #1;
        end
        // Abort collides with a beat and a start; neither may take effect
        i_abort    = 1'b1;
        i_start    = 1'b1;
        i_in_valid = 1'b1;
        @(posedge clk); #1;
        i_abort    = 1'b0;
        i_start    = 1'b0;
        i_in_valid = 1'b0;
        check("abort_done", int'(o_done), 0);
        check("abort_busy", int'(o_busy), 0);
        check("abort_ready", int'(o_in_ready), 0);
        check("abort_beats_left", int'(o_beats_left), 0);
        check("abort_acc", int'(o_acc), n_before);
        @(posedge clk); #1;
        check("abort_idle_done", int'(o_done), 0);
        check("abort_idle_acc", int'(o_acc), n_before);
    endtask

    task automatic run_reset_mid();
        @(posedge clk); #1;
        i_start = 1'b1;
        i_len   = CNT_W'(15);
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_in_valid = 1'b1;
            i_psum     = 16'h0000;
            i_carry    = 4'hF;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("rst_mid_acc", int'(o_acc), 0);
        check("rst_mid_busy", int'(o_busy), 0);
        check("rst_mid_ready", int'(o_in_ready), 0);
        check("rst_mid_done", int'(o_done), 0);
        check("rst_mid_beats_left", int'(o_beats_left), 0);
        i_in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        i_start    = 1'b0;
        i_len      = '0;
        i_abort    = 1'b0;
        i_in_valid = 1'b0;
        i_psum     = '0;
        i_carry    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_acc", int'(o_acc), 0);
        check("reset_busy", int'(o_busy), 0);
        check("reset_ready", int'(o_in_ready), 0);
        check("reset_done", int'(o_done), 0);
        check("reset_beats_left", int'(o_beats_left), 0);
        rst = 1'b0;

        run_burst(3, 0, 1'b0, 1'b0, 16'h0001, 4'h0);
        run_burst(2, 2, 1'b0, 1'b0, 16'h0000, 4'hF);
        run_burst(0, 0, 1'b0, 1'b0, 16'h0000, 4'h0);
        run_abort(4, 2);
        run_burst(3, 1, 1'b1, 1'b0, 16'h0000, 4'h0);
        run_burst(1, 0, 1'b0, 1'b1, 16'h0001, 4'h0);
        run_burst(15, 0, 1'b0, 1'b0, 16'h0000, 4'hF);
        run_reset_mid();

        for (int r = 0; r < 30; r++) begin
            run_burst($urandom_range(0, 15), $urandom_range(0, 2), 1'b1,
                      1'($urandom_range(0, 1)), 16'h0000, 4'h0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/red_seq.md
# red_seq

Multi-cycle sequencer for the EX-stage reduction datapath. It runs a burst of 1..MAX_BEATS partial-sum words through the reduction tree, one word per beat, and accumulates the signed per-beat results into a 16-bit accumulator. While the burst runs it holds the pipeline through `busy`, and it reports completion with a one-cycle `done` pulse. It sits between the EX-stage adder (which supplies `psum`/`carry`) and the hazard unit (which consumes `busy`).

## Interface
- `MAX_BEATS`, default 8: largest burst length; must be ≤ 511 so the accumulator cannot wrap.
- `CNT_W`, default `$clog2(MAX_BEATS+1)`: width of the beat counter.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a burst; sampled only in IDLE or DONE.
- `len`  in  CNT_W  number of beats, sampled with `start`; values above MAX_BEATS are clamped to MAX_BEATS.
- `abort`  in  1  pipeline flush; kills any burst in progress.
- `in_valid`  in  1  `psum`/`carry` carry a valid beat.
- `psum`  in  16  four packed 4-bit partial sums.
- `carry`  in  4  the adder's carry-out bits for this word.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `busy`  out  1  stall request to the hazard unit.
- `done`  out  1  one-cycle completion pulse.
- `acc`  out  16  signed accumulated result.
- `beats_left`  out  CNT_W  beats still outstanding.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_ready`=0, `busy`=0, `done`=0; `acc` holds its last value.
  - `start` with `len`≠0: load count = `len`, clear `acc`, go to RUN.
  - `start` with `len`=0: clear `acc`, go straight to DONE.
- RUN: `in_ready`=1, `busy`=1.
  - Each accepted beat: `acc` ← `acc` + sext16(red(`psum`,`carry`)), and count decrements.
  - Acceptance with count=1 moves to DONE.
  - No `in_valid`: hold state, count and `acc`.
  - `start` is ignored in RUN.
- DONE: `done`=1, `busy`=0, `in_ready`=0. Next state is IDLE, or RUN/DONE if `start` is asserted in that cycle (back-to-back bursts; `acc` is cleared).
- `abort` in any state: next state IDLE, `done` not asserted, count cleared, `acc` keeps its partial value. `abort` wins over a simultaneous `start` or beat (the beat is not accumulated).
- Arithmetic: the per-beat reduction value lies in [-64, 63] and is sign-extended to 16 bits. The sum is two's complement modulo 2^16. MAX_BEATS ≤ 511 guarantees no overflow.
- `beats_left` = count register: `len` during RUN, 0 in IDLE/DONE.

## Timing
- Reset values: state IDLE; `acc`=0, count=0, `in_ready`=0, `busy`=0, `done`=0, `beats_left`=0.
- `start` at edge t → RUN, `in_ready`=1 and `busy`=1 from cycle t+1.
- A beat accepted at edge k is reflected in `acc` after edge k (visible in cycle k+1).
- Last beat at edge k → DONE in cycle k+1, with `done`=1 and the final `acc` valid in the same cycle.
- With continuous `in_valid`, a burst of length N has `done` in cycle t+N+1; `busy` is high for exactly N cycles.
- `len`=0: `done` in cycle t+1, `acc`=0, `busy` never rises.
- Reset asserted mid-burst: immediate return to reset values, with no `done`.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.

## Structure
- Shared ALU package holds:
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The reduction result width constant (16).
  - The per-beat range constants (-64 and 63), used by assertions.
- One sub-module instance: the existing `red` reduction tree, fed directly from `psum`/`carry`. Its combinational output feeds the accumulator adder.
- Everything else (FSM, counter, accumulator, clamp) lives in `red_seq`.

## Test plan
- Reset, then `start` with `len`=3 and three consecutive beats `psum`=16'h0001, `carry`=4'h0 → `done` 4 cycles after `start`, `acc`=16'h0003, `busy` high for exactly 3 cycles.
- `len`=2, beats `psum`=16'h0000, `carry`=4'hF, with `in_valid` low for 2 cycles between beats → `acc`=16'hFF80 (-128), `busy` held through the gap, `beats_left` stays at 1 during the gap.
- `len`=0 → `done` the next cycle, `acc`=0, `in_ready` and `busy` never asserted.
- `len`=4, `abort` after 2 beats of 16'h0001/4'h0 → IDLE the next cycle, no `done`, `acc`=16'h0002, `busy` drops.
- `start` asserted in the DONE cycle with `len`=1 and a beat of 16'h0001/4'h0 → a second `done` 2 cycles later with `acc`=1; `start` during RUN has no effect.
- `len`=15 with MAX_BEATS=8, all beats 16'h0000/4'hF → exactly 8 beats accepted, `acc`=16'hFE00 (-512); `rst` pulsed mid-burst in a repeat run → all outputs at reset values.
